// File: rtl/input_capture_if.sv
// CPU register-port bundle for input_capture: byte-wide address/data with
// single-cycle read and write strobes.
interface input_capture_if;
  logic [7:0] cpu_addr;
  logic       cpu_rd;
  logic       cpu_wr;
  logic [7:0] cpu_din;
  logic [7:0] cpu_dout;

  modport master (output cpu_addr, cpu_rd, cpu_wr, cpu_din, input cpu_dout);
  modport slave  (input cpu_addr, cpu_rd, cpu_wr, cpu_din, output cpu_dout);
endinterface

// File: rtl/input_capture.sv
// Frame-synchronous joystick snapshot with W1C press/release events and
// spinner position accumulation, exposed through an 8-bit CPU register port.
module input_capture #(
  parameter int CHANNELS   = 6,
  parameter int JOY_W      = 32,
  parameter int SPIN_ACC_W = 16
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic                      vs,
  input  logic [CHANNELS*JOY_W-1:0] joystick,
  input  logic [CHANNELS*9-1:0]     spinner,
  input_capture_if.slave            cpu,
  output logic                      frame_irq
);

  localparam int JOY_BYTES = JOY_W / 8;

  logic        vs_q;
  logic        primed;
  logic [15:0] frame_cnt;
  logic        snap_evt;
  logic [2:0]  ch;
  logic [4:0]  off;
  logic [7:0]  global_byte;
  logic [7:0]  rd_byte;
  logic [7:0]  ch_byte [CHANNELS];

  assign snap_evt = vs & ~vs_q;
  assign ch       = cpu.cpu_addr[7:5];
  assign off      = cpu.cpu_addr[4:0];

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      vs_q      <= 1'b0;
      primed    <= 1'b0;
      frame_cnt <= 16'h0000;
      frame_irq <= 1'b0;
    end else begin
      vs_q      <= vs;
      primed    <= 1'b1;
      frame_irq <= snap_evt;
      if (snap_evt)
        frame_cnt <= frame_cnt + 16'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [JOY_W-1:0]      joy;
      logic [JOY_W-1:0]      snap_reg, pressed_reg, released_reg;
      logic [JOY_W-1:0]      pressed_next, released_next;
      logic [JOY_W-1:0]      p_clr, r_clr;
      logic [SPIN_ACC_W-1:0] spin_acc_reg, acc_base, delta;
      logic [8:0]            spin;
      logic                  spin_tq;
      logic                  wr_ch, toggle, spin_zero;
      logic [31:0]           snap_x, pressed_x, released_x;
      logic [15:0]           acc_x;

      assign joy   = joystick[gi*JOY_W +: JOY_W];
      assign spin  = spinner[gi*9 +: 9];
      assign wr_ch = cpu.cpu_wr && (ch == 3'(gi));

      always_comb begin
        p_clr = '0;
        r_clr = '0;
        for (int k = 0; k < JOY_BYTES; k++) begin
          if (wr_ch && off == 5'(4 + k)) p_clr[8*k +: 8] = cpu.cpu_din;
          if (wr_ch && off == 5'(8 + k)) r_clr[8*k +: 8] = cpu.cpu_din;
        end
      end

      // Clear first, then OR in new edges so a coincident edge survives the clear.
      assign pressed_next  = (pressed_reg  & ~p_clr) | (snap_evt ? (joy & ~snap_reg) : '0);
      assign released_next = (released_reg & ~r_clr) | (snap_evt ? (~joy & snap_reg) : '0);

      assign toggle    = primed && (spin[8] != spin_tq);
      assign spin_zero = wr_ch && (off == 5'h0C || off == 5'h0D);
      assign acc_base  = spin_zero ? '0 : spin_acc_reg;
      assign delta     = toggle ? SPIN_ACC_W'($signed(spin[7:0])) : '0;

      always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
          snap_reg     <= '0;
          pressed_reg  <= '0;
          released_reg <= '0;
          spin_acc_reg <= '0;
          spin_tq      <= 1'b0;
        end else begin
          if (snap_evt)
            snap_reg <= joy;
          pressed_reg  <= pressed_next;
          released_reg <= released_next;
          spin_tq      <= spin[8];
          spin_acc_reg <= acc_base + delta;
        end
      end

      // Zero-extend to the full register-map width so unused bytes read 0.
      assign snap_x     = 32'(snap_reg);
      assign pressed_x  = 32'(pressed_reg);
      assign released_x = 32'(released_reg);
      assign acc_x      = 16'(spin_acc_reg);

      always_comb begin
        ch_byte[gi] = 8'h00;
        case (off[4:2])
          3'd0: ch_byte[gi] = snap_x[{off[1:0], 3'b000} +: 8];
          3'd1: ch_byte[gi] = pressed_x[{off[1:0], 3'b000} +: 8];
          3'd2: ch_byte[gi] = released_x[{off[1:0], 3'b000} +: 8];
          3'd3: if (!off[1]) ch_byte[gi] = acc_x[{off[0], 3'b000} +: 8];
          default: ch_byte[gi] = 8'h00;
        endcase
      end
    end
  endgenerate

  always_comb begin
    global_byte = 8'h00;
    case (off)
      5'h00:   global_byte = frame_cnt[7:0];
      5'h01:   global_byte = frame_cnt[15:8];
      5'h02:   global_byte = {7'b0, vs_q};
      5'h03:   global_byte = 8'(CHANNELS);
      default: global_byte = 8'h00;
    endcase
  end

  always_comb begin
    rd_byte = 8'h00;
    if (ch == 3'd7) begin
      rd_byte = global_byte;
    end else begin
      for (int i = 0; i < CHANNELS; i++)
        if (ch == 3'(i)) rd_byte = ch_byte[i];
    end
  end

  // Registered read: sampled state is pre-update for any coincident write/event.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)
      cpu.cpu_dout <= 8'h00;
    else if (cpu.cpu_rd)
      cpu.cpu_dout <= rd_byte;
  end

endmodule
